// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM block.
package pwm_pkg;
  localparam int CW_DEF         = 16;
  localparam int PERIOD_RST_DEF = 49999;

  // Select width for the channel index; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pwm_ch_slice.sv
// One PWM channel: double-buffered duty, compare and output flop.
// PWM_MULTI_FADE_EN makes boundaries step duty_act by one toward duty_sh.
module pwm_ch_slice
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cnt,
  input  logic          boundary,
  input  logic          run,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_duty,
  output logic          pwm
`ifdef PWM_MULTI_FADE_EN
  ,
  output logic          fade_busy
`endif
);
  logic [CW-1:0] duty_sh, duty_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr_en) duty_sh <= wr_duty;
      // duty_act samples the old duty_sh, so a boundary-cycle write waits a period
      if (!run) duty_act <= duty_sh;
      else if (boundary) begin
`ifdef PWM_MULTI_FADE_EN
        if (duty_act < duty_sh)      duty_act <= duty_act + CW'(1);
        else if (duty_act > duty_sh) duty_act <= duty_act - CW'(1);
`else
        duty_act <= duty_sh;
`endif
      end
      pwm <= run && (cnt < duty_act);
    end
  end

`ifdef PWM_MULTI_FADE_EN
  assign fade_busy = (duty_act != duty_sh);
`endif
endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM with shared period counter, start/stop latch and boundary tick.
// Optional linear duty fade and fade_busy outputs under PWM_MULTI_FADE_EN.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = CW_DEF,
  parameter int PERIOD_RST = PERIOD_RST_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        strt,
  input  logic                        stp,
  input  logic [CW-1:0]               period,
  input  logic                        wr_en,
  input  logic [clog2_min1(NCH)-1:0]  wr_ch,
  input  logic [CW-1:0]               wr_duty,
  output logic [NCH-1:0]              pwm,
  output logic                        run,
  output logic                        tick
`ifdef PWM_MULTI_FADE_EN
  ,
  output logic [NCH-1:0]              fade_busy
`endif
);
  logic [CW-1:0]  cnt, period_q;
  logic           bnd;
  logic [NCH-1:0] wr_sel;

  assign bnd = (cnt == period_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      cnt      <= '0;
      period_q <= CW'(PERIOD_RST);
      tick     <= 1'b0;
    end else begin
      if (!stp)       run <= 1'b0;
      else if (!strt) run <= 1'b1;

      if (!run) begin
        cnt      <= '0;
        period_q <= period;
        tick     <= 1'b0;
      end else begin
        // wrap only through the terminal compare; cnt never exceeds period_q
        cnt  <= bnd ? '0 : cnt + CW'(1);
        tick <= bnd;
        if (bnd) period_q <= period;
      end
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++)
      wr_sel[i] = wr_en && (32'(wr_ch) == i);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_ch_slice #(.CW(CW)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt),
      .boundary (bnd),
      .run      (run),
      .wr_en    (wr_sel[i]),
      .wr_duty  (wr_duty),
      .pwm      (pwm[i])
`ifdef PWM_MULTI_FADE_EN
      ,
      .fade_busy(fade_busy[i])
`endif
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: vector table plus multi-cycle sequences.
module tb_pwm_multi_ch;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           strt = 1'b1, stp = 1'b1;
  logic [CW-1:0]  period = '0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [CW-1:0]  wr_duty = '0;
  logic [NCH-1:0] pwm;
  logic           run, tick;
`ifdef PWM_MULTI_FADE_EN
  logic [NCH-1:0] fade_busy;
`endif

  int n_chk = 0;
  int n_fail = 0;

  pwm_multi_ch #(.NCH(NCH), .CW(CW), .PERIOD_RST(49999)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .stp(stp), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm(pwm), .run(run), .tick(tick)
`ifdef PWM_MULTI_FADE_EN
    , .fade_busy(fade_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int duty[4];
    int k;
    int hi[4];
    int tk;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_ch = ch[1:0]; wr_duty = d[CW-1:0];
    step();
    wr_en = 1'b0;
  endtask

  task automatic stop();
    stp = 1'b0; step(); stp = 1'b1; step();
  endtask

  // leaves the bench at sample 0: pwm/tick reflect cnt==0 of the first period
  task automatic start();
    strt = 1'b0; step(); strt = 1'b1; step();
  endtask

  initial begin
    int hi[4];
    int tk, ft;
    int per_hi[5];
    int tq[$];

    vecs[0] = '{9, '{0, 3, 9, 12},     2, '{0, 6, 18, 20}, 2};
    vecs[1] = '{4, '{1, 5, 4, 2},      2, '{2, 10, 8, 4},  2};
    vecs[2] = '{0, '{0, 1, 2, 0},      3, '{0, 3, 3, 0},   3};
    vecs[3] = '{7, '{8, 0, 7, 65535},  1, '{8, 0, 7, 8},   1};

    // reset state
    #12;
    chk("rst_run", int'(run), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_tick", int'(tick), 0);
    step();
    rst_n = 1'b1;
    step();

    // table: high cycles per channel and ticks over k full periods
    for (int v = 0; v < 4; v++) begin
      stop();
      period = CW'(vecs[v].period);
      for (int c = 0; c < NCH; c++) wr(c, vecs[v].duty[c]);
      step(); step();
      start();
      hi = '{0, 0, 0, 0}; tk = 0;
      for (int j = 0; j < vecs[v].k * (vecs[v].period + 1); j++) begin
        for (int c = 0; c < NCH; c++) if (pwm[c]) hi[c]++;
        if (tick) tk++;
        step();
      end
      for (int c = 0; c < NCH; c++)
        chk($sformatf("vec%0d_ch%0d_hi", v, c), hi[c], vecs[v].hi[c]);
      chk($sformatf("vec%0d_ticks", v), tk, vecs[v].tk);
    end

    // double buffering: mid-period write, boundary-cycle write, last write wins
    stop();
    period = 16'd9;
    wr(0, 0); wr(1, 3); wr(2, 0); wr(3, 0);
    step();
    start();
    per_hi = '{0, 0, 0, 0, 0}; tk = 0;
    for (int g = 0; g < 50; g++) begin
      if (pwm[1]) per_hi[g / 10]++;
      if (tick) tk++;
      case (g)
        3:  begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 16'd7; end
        18: begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 16'd2; end
        32: begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 16'd5; end
        33: begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 16'd6; end
        default: ;
      endcase
      step();
      wr_en = 1'b0;
    end
    chk("dbuf_p0", per_hi[0], 3);
    chk("dbuf_p1", per_hi[1], 7);
    chk("dbuf_p2", per_hi[2], 7);
    chk("dbuf_p3", per_hi[3], 2);
    chk("dbuf_p4", per_hi[4], 6);
    chk("dbuf_ticks", tk, 5);

    // stop wins over start
    stop();
    strt = 1'b0; stp = 1'b0; step();
    strt = 1'b1; stp = 1'b1;
    chk("both_low_run", int'(run), 0);
    step();
    chk("both_low_run2", int'(run), 0);

    // stop mid-period, then restart into a fresh period
    wr(1, 9);
    step();
    start();
    for (int j = 0; j < 5; j++) step();
    stp = 1'b0; step(); stp = 1'b1;
    chk("stop_run", int'(run), 0);
    step();
    chk("stop_pwm", int'(pwm), 0);
    chk("stop_tick", int'(tick), 0);
    start();
    ft = -1; hi[1] = 0;
    for (int j = 0; j < 15; j++) begin
      if (tick && ft < 0) ft = j;
      if (j < 10 && pwm[1]) hi[1]++;
      step();
    end
    chk("restart_first_tick", ft, 9);
    chk("restart_ch1_hi", hi[1], 9);

    // period change mid-period takes effect at the next boundary
    stop();
    period = 16'd9;
    start();
    tq.delete();
    for (int g = 0; g < 21; g++) begin
      if (tick) tq.push_back(g);
      if (g == 3) period = 16'd4;
      step();
    end
    chk("per_chg_nticks", tq.size(), 3);
    chk("per_chg_t0", (tq.size() > 0) ? tq[0] : -1, 9);
    chk("per_chg_t1", (tq.size() > 1) ? tq[1] : -1, 14);
    chk("per_chg_t2", (tq.size() > 2) ? tq[2] : -1, 19);

    // asynchronous reset mid-operation with period 0 (tick held high)
    stop();
    period = 16'd0;
    wr(1, 1);
    step();
    start();
    step();
    chk("p0_tick_high", int'(tick), 1);
    chk("p0_ch1_high", int'(pwm[1]), 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_run", int'(run), 0);
    chk("async_rst_tick", int'(tick), 0);
    step();
    rst_n = 1'b1;
    step();
    period = 16'd9;
    start();
    tk = 0; hi[0] = 0;
    for (int j = 0; j < 10; j++) begin
      if (pwm != '0) hi[0]++;
      if (tick) tk++;
      step();
    end
    chk("post_rst_duty_cleared", hi[0], 0);
    chk("post_rst_ticks", tk, 1);

`ifdef PWM_MULTI_FADE_EN
    // fade: duty 0 -> 3 steps one count per boundary
    stop();
    period = 16'd3;
    start();
    per_hi = '{0, 0, 0, 0, 0};
    begin
      int busy[4];
      for (int g = 0; g < 16; g++) begin
        if (pwm[0]) per_hi[g / 4]++;
        if (g % 4 == 1) busy[g / 4] = int'(fade_busy[0]);
        if (g == 1) begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 16'd3; end
        step();
        wr_en = 1'b0;
      end
      chk("fade_p0", per_hi[0], 0);
      chk("fade_p1", per_hi[1], 1);
      chk("fade_p2", per_hi[2], 2);
      chk("fade_p3", per_hi[3], 3);
      chk("fade_busy_p1", busy[1], 1);
      chk("fade_busy_p2", busy[2], 1);
      chk("fade_busy_p3", busy[3], 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
